// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 8x8 MAC: clears the accumulator, streams operand pairs,
// waits out the MAC latency, then returns the accumulator LSB-first as bytes.
module mac_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int LEN_W   = 4,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = (ACC_W + 7) / 8;
  localparam int RES_W  = NBYTES * 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAT_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_WAIT, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q;
  logic [LAT_W-1:0]   lat_q;
  logic [IDX_W-1:0]   idx_q;
  logic [RES_W-1:0]   result_q;
  logic               done_q;
  logic               kill, beat, out_acc, last_byte, lat_last;

  always_comb begin
    state_d   = state_q;
    kill      = ena && abort && (state_q != S_IDLE);
    beat      = ena && !abort && (state_q == S_ACCUM) && in_valid;
    out_acc   = ena && !abort && (state_q == S_SEND) && out_ready;
    last_byte = out_acc && (idx_q == IDX_W'(NBYTES - 1));
    lat_last  = (lat_q == LAT_W'(MAC_LAT - 1));
    if (kill) begin
      state_d = S_IDLE;
    end else if (ena) begin
      case (state_q)
        S_IDLE:  if (start && (len != '0)) state_d = S_CLEAR;
        S_CLEAR: state_d = S_ACCUM;
        S_ACCUM: if (beat && (cnt_q == LEN_W'(1))) state_d = S_WAIT;
        S_WAIT:  if (lat_last) state_d = S_SEND;
        S_SEND:  if (last_byte) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Everything is frozen while ena is low, including the pending done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      done_q  <= last_byte;
      if (kill) begin
        cnt_q <= '0;
        lat_q <= '0;
        idx_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start && (len != '0)) cnt_q <= len;
          S_ACCUM: begin
            lat_q <= '0;
            if (beat) cnt_q <= cnt_q - LEN_W'(1);
          end
          S_WAIT: begin
            lat_q <= lat_q + LAT_W'(1);
            if (lat_last) begin
              result_q <= RES_W'(mac_acc);
              idx_q    <= '0;
            end
          end
          S_SEND: if (out_acc) idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = ena && !abort && (state_q == S_ACCUM);
  assign mac_en    = beat;
  assign mac_a     = beat ? a_in : '0;
  assign mac_b     = beat ? b_in : '0;
  assign mac_clr   = ena && (state_q == S_CLEAR);
  assign out_valid = ena && (state_q == S_SEND);
  assign out_byte  = (state_q == S_SEND) ? result_q[8*idx_q +: 8] : 8'h00;
  assign busy      = (state_q != S_IDLE);
  assign done      = ena && done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: stimulus pushes expected result bytes,
// a negedge monitor pops and compares whenever a byte is handed over.
module tb_mac_seq_ctrl;
  localparam int DATA_W = 8, ACC_W = 20, LEN_W = 4, MAC_LAT = 1;

  logic clk = 0, rst_n = 0, ena = 0, start = 0, abort = 0;
  logic in_valid = 0, out_ready = 0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] a_in = '0, b_in = '0;
  logic in_ready, mac_clr, mac_en, out_valid, busy, done;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [ACC_W-1:0]  mac_acc;
  logic [7:0]        out_byte;

  int checks = 0, failures = 0, done_cnt = 0, busy_cnt = 0, d0;
  logic [7:0] exp_q[$];
  logic stall_prev = 0;
  logic [7:0] stall_byte = 0;
  bit ok;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .busy(busy), .done(done)
  );

  // MAC model, latency 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else if (mac_en)  mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mac_en) begin
        check("mac_en_on_beat", {30'd0, in_valid, in_ready}, 32'd3);
        check("mac_operands", {16'd0, mac_a, mac_b}, {16'd0, a_in, b_in});
      end else if (in_valid) begin
        check("mac_operands_zero", {16'd0, mac_a, mac_b}, 32'd0);
      end
      if (stall_prev && out_valid) check("out_byte_stable", {24'd0, out_byte}, {24'd0, stall_byte});
      stall_prev = out_valid && !out_ready;
      stall_byte = out_byte;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_byte");
        else check("out_byte", {24'd0, out_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l, input logic [23:0] r);
    for (int i = 0; i < 3; i++) exp_q.push_back(r[8*i +: 8]);
    start = 1;
    len = LEN_W'(l);
    tick();
    start = 0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 0;
    in_valid = 1; a_in = a; b_in = b;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        tick();
      end
    end
    in_valid = 0; a_in = '0; b_in = '0;
    if (!got) fail_now("feed_timeout");
  endtask

  task automatic wait_idle(input int maxc);
    bit got;
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) fail_now("idle_timeout");
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit got;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) fail_now("valid_timeout");
  endtask

  task automatic check_zero(input string name);
    check(name, {2'd0, in_ready, mac_clr, mac_en, mac_a, mac_b, out_valid, out_byte, busy, done}, 32'd0);
  endtask

  initial begin
    #100_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state
    ena = 1;
    #12;
    check_zero("reset_outputs");
    tick();
    rst_n = 1;
    tick();

    // Basic job
    out_ready = 1;
    busy_cnt = 0;
    d0 = done_cnt;
    start_job(4, 24'h000027);
    feed(8'd3, 8'd2); feed(8'd1, 8'd4); feed(8'd5, 8'd3); feed(8'd7, 8'd2);
    wait_idle(30);
    check("basic_busy_cycles", busy_cnt, 32'd9);
    check("basic_done", done_cnt - d0, 32'd1);
    check("basic_drained", exp_q.size(), 32'd0);

    // Maximum job
    d0 = done_cnt;
    start_job(15, 24'h0EE20F);
    for (int i = 0; i < 15; i++) feed(8'd255, 8'd255);
    wait_idle(30);
    check("max_done", done_cnt - d0, 32'd1);
    check("max_drained", exp_q.size(), 32'd0);

    // Backpressure on both sides
    d0 = done_cnt;
    out_ready = 0;
    start_job(4, 24'h000027);
    feed(8'd3, 8'd2); tick(); feed(8'd1, 8'd4); tick();
    feed(8'd5, 8'd3); tick(); feed(8'd7, 8'd2);
    for (int k = 0; k < 3; k++) begin
      wait_valid();
      #1;
      repeat (3) tick();
      out_ready = 1;
      tick();
      out_ready = 0;
    end
    wait_idle(30);
    check("bp_done", done_cnt - d0, 32'd1);
    check("bp_drained", exp_q.size(), 32'd0);
    out_ready = 1;

    // len=0 request is ignored
    d0 = done_cnt;
    start = 1; len = '0;
    tick();
    start = 0;
    @(negedge clk);
    check("len0_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("len0_no_done", done_cnt - d0, 32'd0);
    #1;

    // start while in ACCUM is ignored
    d0 = done_cnt;
    start_job(2, 24'h00001A);
    feed(8'd2, 8'd3);
    start = 1; len = 4'd5;
    tick();
    start = 0;
    feed(8'd4, 8'd5);
    wait_idle(30);
    check("restart_done", done_cnt - d0, 32'd1);
    check("restart_drained", exp_q.size(), 32'd0);

    // Abort after 2 beats, with a simultaneous offered beat
    d0 = done_cnt;
    start = 1; len = 4'd4;
    tick();
    start = 0;
    feed(8'd1, 8'd1); feed(8'd2, 8'd2);
    abort = 1; in_valid = 1; a_in = 8'd9; b_in = 8'd9;
    @(negedge clk);
    check("abort_no_beat", {31'd0, mac_en}, 32'd0);
    tick();
    abort = 0; in_valid = 0; a_in = '0; b_in = '0;
    @(negedge clk);
    check("abort_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    #1;
    d0 = done_cnt;
    start_job(1, 24'h000001);
    feed(8'd1, 8'd1);
    wait_idle(30);
    check("post_abort_done", done_cnt - d0, 32'd1);
    check("post_abort_drained", exp_q.size(), 32'd0);

    // ena dropped in SEND after byte 0
    d0 = done_cnt;
    start_job(4, 24'h01E86A);
    feed(8'd200, 8'd250); feed(8'd255, 8'd255); feed(8'd100, 8'd100); feed(8'd3, 8'd3);
    wait_valid();
    tick();
    ena = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ena_hold", {30'd0, out_valid, busy}, 32'd1);
      tick();
    end
    check("ena_pending", exp_q.size(), 32'd2);
    ena = 1;
    wait_idle(30);
    check("ena_done", done_cnt - d0, 32'd1);
    check("ena_drained", exp_q.size(), 32'd0);

    // Reset mid-ACCUM
    start = 1; len = 4'd3;
    tick();
    start = 0;
    feed(8'd5, 8'd5);
    in_valid = 1; a_in = 8'd6; b_in = 8'd6;
    rst_n = 0;
    #1;
    check_zero("reset_mid_job");
    in_valid = 0; a_in = '0; b_in = '0;
    tick();
    rst_n = 1;
    tick();
    d0 = done_cnt;
    start_job(1, 24'h000006);
    feed(8'd2, 8'd3);
    wait_idle(30);
    check("post_reset_done", done_cnt - d0, 32'd1);
    check("final_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the 8x8 multiply-accumulate datapath. Runs one dot-product job of programmable length: clears the accumulator, feeds operand pairs from a valid/ready stream into the MAC and waits out the MAC latency. It then captures the accumulator and returns it byte-serially over an 8-bit valid/ready output. It sits between the pin-level I/O wrapper and the MAC core.

Parameters:
DATA_W, 8, operand width (a and b)
ACC_W, 20, MAC accumulator width
LEN_W, 4, width of the job-length field (max 15 pairs)
MAC_LAT, 1, cycles from a mac_en beat until mac_acc reflects it (must be 1 or more)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  design enable; 0 freezes the block
start  in  1  job request, sampled in IDLE only
len  in  LEN_W  number of operand pairs for the job; sampled with start
abort  in  1  synchronous job cancel
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts a pair
a_in  in  DATA_W  operand A
b_in  in  DATA_W  operand B
mac_clr  out  1  accumulator clear strobe to MAC
mac_en  out  1  accumulate strobe to MAC
mac_a  out  DATA_W  operand A to MAC
mac_b  out  DATA_W  operand B to MAC
mac_acc  in  ACC_W  MAC accumulator value
out_valid  out  1  result byte valid
out_ready  in  1  consumer accepts the byte
out_byte  out  8  result byte, least-significant byte first
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result byte is accepted

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; pair counter, byte index and result register cleared. All outputs 0, including mac_a/mac_b.
- NBYTES = ceil(ACC_W/8), which is 3 by default. The result is zero-extended to NBYTES*8 bits.
- States and transitions:
  - IDLE: start=1 and len!=0 -> CLEAR. start=1 with len=0 is ignored (no busy, no done).
  - CLEAR: mac_clr=1 for exactly one cycle; counter<=len -> ACCUM.
  - ACCUM: in_ready=1. A beat is in_valid&in_ready.
    - On a beat: mac_en=1 in that same cycle; mac_a=a_in and mac_b=b_in combinationally (zero outside beats); counter decrements.
    - The beat with counter==1 -> WAIT.
  - WAIT: MAC_LAT cycles. At the final WAIT edge, result<=mac_acc and byte index<=0 -> SEND.
  - SEND: out_valid=1; out_byte=result[8*idx +: 8].
    - out_valid&out_ready advances idx.
    - Acceptance of byte NBYTES-1 -> IDLE, with done=1 in the following cycle.
- Job latency with no stalls: 1 (CLEAR) + len (ACCUM) + MAC_LAT (WAIT) + NBYTES (SEND) cycles from the start edge.
- start while busy: ignored. len is sampled only on the IDLE->CLEAR edge.
- Stall on in_valid=0 in ACCUM: remain in ACCUM, mac_en=0, counter held.
- Stall on out_ready=0 in SEND: out_valid stays 1; out_byte stays stable.
- abort=1 (with ena=1) in any non-IDLE state:
  - next state is IDLE; no done pulse; counter and index cleared; accumulator contents unspecified.
  - abort takes priority over a simultaneous beat: mac_en=0 that cycle.
- ena=0: all state, counters and result are held. in_ready, mac_en, mac_clr, out_valid and done are forced to 0. start and abort are ignored. When ena returns to 1, operation resumes exactly where it stopped.
- Reset asserted mid-job: immediate return to the reset values above.
- Arithmetic is performed by the MAC only; the controller never modifies the accumulator value. Overflow of ACC_W is the MAC's concern (the default sizing cannot overflow at len 15 or below).

Test Plan:
- Bench MAC model: acc<=clr?0:en?acc+a*b:acc, with latency 1.
- Basic job: len=4, pairs (3,2),(1,4),(5,3),(7,2) streamed back-to-back, out_ready=1.
  - Required: out_byte sequence 0x27, 0x00, 0x00; done pulses once.
  - Required: busy is high for 1+4+1+3 = 9 cycles.
- Maximum job: len=15, all pairs (255,255).
  - Required: result 975375 = 0xEE20F; bytes 0x0F, 0xE2, 0x0E.
- Backpressure on both sides: same four pairs as the basic job, in_valid toggled 1-0-1-0, out_ready held low 3 cycles per byte.
  - Required: identical bytes; mac_en only on beats; out_byte stable while stalled.
- Edge requests:
  - len=0 start -> no state change, busy=0, no done.
  - start while in ACCUM -> ignored; the current job completes unaffected.
- Abort mid-ACCUM after 2 beats, then a new job with len=1, pair (1,1).
  - Required: IDLE one cycle after abort, no done; the new job yields 0x01, 0x00, 0x00.
- ena dropped for 5 cycles in SEND (after byte 0), then rst_n pulsed low mid-ACCUM of a second job.
  - Required: SEND resumes at byte 1 with the correct value.
  - Required: the reset immediately returns all outputs to 0 and state to IDLE.
